// File: rtl/router_pkt_rx_if.sv
// Source-side and FIFO-side signals of the router packet receiver.
// master = source driver / FIFO bank view, slave = receiver view.
interface router_pkt_rx_if #(
    parameter int NUM_DEST = 3,
    parameter int CNT_W    = 16
);
    logic [7:0]          data_in;
    logic                pkt_vld;
    logic [NUM_DEST-1:0] fifo_full;
    logic                busy;
    logic                error;
    logic [7:0]          dout;
    logic [NUM_DEST-1:0] write_enb;
    logic [CNT_W-1:0]    pkt_cnt;
    logic [CNT_W-1:0]    err_cnt;

    modport master (
        output data_in, pkt_vld, fifo_full,
        input  busy, error, dout, write_enb, pkt_cnt, err_cnt
    );

    modport slave (
        input  data_in, pkt_vld, fifo_full,
        output busy, error, dout, write_enb, pkt_cnt, err_cnt
    );
endinterface

// File: rtl/router_pkt_rx.sv
// 1xN router input receiver: parses header/payload/parity and steers each byte to one FIFO write port, one cycle after acceptance.
// busy stalls the source while a header waits for room, during the CHECK cycle, and while the selected FIFO is full.
module router_pkt_rx #(
    parameter int NUM_DEST = 3,
    parameter int CNT_W    = 16
) (
    input  logic           clock,
    input  logic           reset,
    router_pkt_rx_if.slave bus
);
    typedef struct packed {
        logic [5:0] len;
        logic [1:0] dest;
    } hdr_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HDR,
        LOAD,
        PARITY,
        CHECK,
        DROP
    } state_t;

    state_t              state_q, state_n;
    logic [1:0]          dest_q, dest_n;
    logic [5:0]          rem_q, rem_n;
    logic [7:0]          par_q, par_n;
    logic [7:0]          hdr_q, hdr_n;
    logic                mism_q, mism_n;
    logic [7:0]          dout_q, dout_n;
    logic [NUM_DEST-1:0] wen_q, wen_n;
    logic                error_q, error_n;
    logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_n;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_n;

    hdr_t hdr_in;
    logic cur_full;
    logic busy;
    logic accept;

    function automatic logic full_of(input logic [1:0] d, input logic [NUM_DEST-1:0] ff);
        logic f;
        f = 1'b0;
        for (int i = 0; i < NUM_DEST; i++) begin
            if (d == 2'(i)) f = ff[i];
        end
        return f;
    endfunction

    function automatic logic dest_valid(input logic [1:0] d);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < NUM_DEST; i++) begin
            if (d == 2'(i)) ok = 1'b1;
        end
        return ok;
    endfunction

    function automatic logic [NUM_DEST-1:0] onehot(input logic [1:0] d);
        logic [NUM_DEST-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_DEST; i++) begin
            if (d == 2'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    // busy depends only on registered state and the FIFO flags, never on data_in.
    always_comb begin
        hdr_in   = hdr_t'(bus.data_in);
        cur_full = full_of(dest_q, bus.fifo_full);
        case (state_q)
            WAIT_HDR, CHECK: busy = 1'b1;
            LOAD, PARITY:    busy = cur_full;
            default:         busy = 1'b0;
        endcase
        accept = bus.pkt_vld && !busy;
    end

    always_comb begin
        state_n   = state_q;
        dest_n    = dest_q;
        rem_n     = rem_q;
        par_n     = par_q;
        hdr_n     = hdr_q;
        mism_n    = mism_q;
        dout_n    = dout_q;
        wen_n     = '0;
        error_n   = error_q;
        pkt_cnt_n = pkt_cnt_q;
        err_cnt_n = err_cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    dest_n  = hdr_in.dest;
                    rem_n   = hdr_in.len;
                    par_n   = bus.data_in;
                    hdr_n   = bus.data_in;
                    error_n = 1'b0;
                    if (!dest_valid(hdr_in.dest) || hdr_in.len == 6'd0) begin
                        state_n = DROP;
                    end else if (full_of(hdr_in.dest, bus.fifo_full)) begin
                        state_n = WAIT_HDR;
                    end else begin
                        dout_n  = bus.data_in;
                        wen_n   = onehot(hdr_in.dest);
                        state_n = LOAD;
                    end
                end
            end

            WAIT_HDR: begin
                if (!cur_full) begin
                    dout_n  = hdr_q;
                    wen_n   = onehot(dest_q);
                    state_n = LOAD;
                end
            end

            LOAD: begin
                if (accept) begin
                    dout_n = bus.data_in;
                    wen_n  = onehot(dest_q);
                    par_n  = par_q ^ bus.data_in;
                    rem_n  = rem_q - 6'd1;
                    if (rem_q == 6'd1) state_n = PARITY;
                end
            end

            PARITY: begin
                if (accept) begin
                    dout_n  = bus.data_in;
                    wen_n   = onehot(dest_q);
                    mism_n  = (bus.data_in != par_q);
                    state_n = CHECK;
                end
            end

            CHECK: begin
                if (mism_q) begin
                    error_n   = 1'b1;
                    err_cnt_n = err_cnt_q + CNT_W'(1);
                end else begin
                    pkt_cnt_n = pkt_cnt_q + CNT_W'(1);
                end
                state_n = IDLE;
            end

            DROP: begin
                // Bytes are swallowed until the source drops pkt_vld.
                if (!bus.pkt_vld) begin
                    error_n   = 1'b1;
                    err_cnt_n = err_cnt_q + CNT_W'(1);
                    state_n   = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            dest_q    <= '0;
            rem_q     <= '0;
            par_q     <= '0;
            hdr_q     <= '0;
            mism_q    <= 1'b0;
            dout_q    <= 8'h00;
            wen_q     <= '0;
            error_q   <= 1'b0;
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_n;
            dest_q    <= dest_n;
            rem_q     <= rem_n;
            par_q     <= par_n;
            hdr_q     <= hdr_n;
            mism_q    <= mism_n;
            dout_q    <= dout_n;
            wen_q     <= wen_n;
            error_q   <= error_n;
            pkt_cnt_q <= pkt_cnt_n;
            err_cnt_q <= err_cnt_n;
        end
    end

    assert property (@(posedge clock) $onehot0(wen_q));

    assign bus.busy      = busy;
    assign bus.error     = error_q;
    assign bus.dout      = dout_q;
    assign bus.write_enb = wen_q;
    assign bus.pkt_cnt   = pkt_cnt_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule
